// File: rtl/counter_pkg.sv
// Shared types and default sizing for the tick counter slice.
package counter_pkg;

  typedef enum logic {ST_STOPPED, ST_RUNNING} run_state_t;

  localparam int unsigned DEFAULT_WIDTH       = 8;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/tick_counter_if.sv
// Control/status bundle between the run-control source and the tick counter.
interface tick_counter_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             tick_in;
  logic             start;
  logic             stop;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             tc;

  modport master (
    output tick_in, start, stop, clear, load, load_val, up_dn,
    input  count, running, tc
  );

  modport slave (
    input  tick_in, start, stop, clear, load, load_val, up_dn,
    output count, running, tc
  );

endinterface

// File: rtl/tick_sync_edge.sv
// Synchronises tick_in into clk and emits a registered one-cycle step per rising edge.
module tick_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_in,
  output logic step
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // All history resets high so a tick_in already high at release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      step   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      step   <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/tick_counter.sv
// Run-controlled up/down counter advanced by tick_in rising edges.
// Define COUNTER_SATURATE_EN to hold at the direction limit instead of wrapping.
module tick_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned RESET_VAL   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  tick_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(RESET_VAL);

  run_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             running_q;
  logic             step;
  logic             at_limit_c;

  tick_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_in (bus.tick_in),
    .step    (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STOPPED;
      running_q <= 1'b0;
      count_q   <= CNT_RST;
      tc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUNNING);
      count_q   <= count_d;
      tc_q      <= tc_d;
    end
  end

  // Run control plus count update; clear > load > step > hold.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tc_d       = 1'b0;
    at_limit_c = bus.up_dn ? (count_q == CNT_MAX) : (count_q == '0);

    if (state_q == ST_STOPPED) begin
      if (bus.start && !bus.stop) state_d = ST_RUNNING;
    end else begin
      if (bus.stop) state_d = ST_STOPPED;
    end

    if (bus.clear) begin
      count_d = CNT_RST;
    end else if (bus.load) begin
      count_d = bus.load_val;
    end else if (step && state_q == ST_RUNNING) begin
      tc_d = at_limit_c;
`ifdef COUNTER_SATURATE_EN
      if (!at_limit_c) count_d = bus.up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
`else
      count_d = bus.up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
`endif
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.tc      = tc_q;

endmodule

// File: tb/tb_tick_counter.sv
// Directed self-checking bench for tick_counter (wrap or COUNTER_SATURATE_EN build).
module tb_tick_counter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic [7:0] held;

  tick_counter_if #(.WIDTH(8)) bus ();

  tick_counter #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .RESET_VAL   (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One tick_in rise: count must be unchanged 2 edges after capture, updated on the third.
  task automatic tick_step(input string tag, input logic [7:0] prev, input logic [7:0] exp,
                           input logic exp_tc);
    bus.tick_in = 1'b1;
    cyc(3);
    check({tag, "_early"}, bus.count, prev);
    cyc(1);
    check({tag, "_cnt"}, bus.count, exp);
    check({tag, "_tc"}, bus.tc, exp_tc);
    bus.tick_in = 1'b0;
    cyc(1);
    check({tag, "_tc_end"}, bus.tc, 0);
    cyc(2);
  endtask

  task automatic tick_idle();
    bus.tick_in = 1'b1;
    cyc(4);
    bus.tick_in = 1'b0;
    cyc(3);
  endtask

  task automatic pulse_start(input logic s, input logic p);
    bus.start = s;
    bus.stop  = p;
    cyc(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    bus.tick_in  = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 8'h00;
    bus.up_dn    = 1'b1;

    // 1: reset with tick_in high, no spurious step after release
    cyc(3);
    check("rst_count", bus.count, 0);
    check("rst_running", bus.running, 0);
    check("rst_tc", bus.tc, 0);
    rst_n = 1'b1;
    cyc(1);
    pulse_start(1'b1, 1'b0);
    check("start_running", bus.running, 1);
    cyc(6);
    check("held_high_no_step", bus.count, 0);
    bus.tick_in = 1'b0;
    cyc(3);

    // 2: five up steps with latency check
    for (int i = 0; i < 5; i++)
      tick_step($sformatf("up%0d", i), 8'(i), 8'(i + 1), 1'b0);
    check("up_total", bus.count, 5);

    // 3: load FE then three up steps across the top
    bus.load_val = 8'hFE;
    bus.load     = 1'b1;
    cyc(1);
    bus.load     = 1'b0;
    check("load_fe", bus.count, 8'hFE);
`ifdef COUNTER_SATURATE_EN
    tick_step("top0", 8'hFE, 8'hFF, 1'b0);
    tick_step("top1", 8'hFF, 8'hFF, 1'b1);
    tick_step("top2", 8'hFF, 8'hFF, 1'b1);
`else
    tick_step("top0", 8'hFE, 8'hFF, 1'b0);
    tick_step("top1", 8'hFF, 8'h00, 1'b1);
    tick_step("top2", 8'h00, 8'h01, 1'b0);
`endif

    // 4: clear, then one down step from zero
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    check("clear", bus.count, 0);
    bus.up_dn = 1'b0;
`ifdef COUNTER_SATURATE_EN
    tick_step("dn0", 8'h00, 8'h00, 1'b1);
`else
    tick_step("dn0", 8'h00, 8'hFF, 1'b1);
`endif
    held = bus.count;

    // 5: stop, then start+stop together stays stopped, ticks discarded
    pulse_start(1'b0, 1'b1);
    check("stop_running", bus.running, 0);
    pulse_start(1'b1, 1'b1);
    check("start_stop_running", bus.running, 0);
    tick_idle();
    tick_idle();
    check("stopped_hold", bus.count, held);

    // 6: resume from held value, then clear/load vs step priority
    pulse_start(1'b1, 1'b0);
    check("resume_running", bus.running, 1);
    bus.up_dn = 1'b1;
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    bus.load_val = 8'h55;
    bus.tick_in  = 1'b1;
    cyc(3);
    bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    check("load_beats_step", bus.count, 8'h55);
    check("load_beats_step_tc", bus.tc, 0);
    bus.tick_in = 1'b0;
    cyc(3);
    bus.load_val = 8'hFF;
    bus.tick_in  = 1'b1;
    cyc(3);
    bus.clear = 1'b1;
    bus.load  = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    check("clear_beats_all", bus.count, 0);
    check("clear_beats_all_tc", bus.tc, 0);
    bus.tick_in = 1'b0;
    cyc(3);
    tick_step("mid", 8'h00, 8'h01, 1'b0);

    // async reset mid-count, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", bus.count, 0);
    check("async_rst_running", bus.running, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check("post_rst_running", bus.running, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
